// File: rtl/mem_access_ctrl_pkg.sv
// Shared encodings for the memory access controller: access sizes, FSM states,
// watchdog default and the alignment rule used to reject requests up front.
package mem_access_ctrl_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_REQ  = 2'b01,
    ST_WAIT = 2'b10,
    ST_DONE = 2'b11
  } state_e;

  localparam int unsigned MAX_WAIT_DEFAULT = 255;

  // The reserved size encoding is treated as a misaligned access.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lsb);
    case (size)
      SZ_BYTE: return 1'b0;
      SZ_HALF: return lsb[0];
      SZ_WORD: return lsb != 2'b00;
      default: return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_ctrl_align.sv
// Byte-lane steering: store strobes and data replication, and load data
// extraction with zero/sign extension. Purely combinational.
module mem_align
  import mem_access_ctrl_pkg::*;
(
  input  logic        we_i,
  input  logic [1:0]  size_i,
  input  logic [1:0]  lsb_i,
  input  logic        signed_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  wstrb_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o
);

  logic [7:0]  rd_byte;
  logic [15:0] rd_half;

  function automatic logic [31:0] ext8(input logic [7:0] b, input logic sgn);
    return sgn ? {{24{b[7]}}, b} : {24'h0, b};
  endfunction

  function automatic logic [31:0] ext16(input logic [15:0] h, input logic sgn);
    return sgn ? {{16{h[15]}}, h} : {16'h0, h};
  endfunction

  // Aligned accesses only reach here, so lane selection equals the addr*8 shift.
  assign rd_byte = rdata_i[{lsb_i, 3'b000} +: 8];
  assign rd_half = rdata_i[{lsb_i[1], 4'b0000} +: 16];

  always_comb begin
    wstrb_o = 4'b0000;
    wdata_o = wdata_i;
    rdata_o = rdata_i;
    case (size_i)
      SZ_BYTE: begin
        wstrb_o = 4'b0001 << lsb_i;
        wdata_o = {4{wdata_i[7:0]}};
        rdata_o = ext8(rd_byte, signed_i);
      end
      SZ_HALF: begin
        wstrb_o = lsb_i[1] ? 4'b1100 : 4'b0011;
        wdata_o = {2{wdata_i[15:0]}};
        rdata_o = ext16(rd_half, signed_i);
      end
      default: begin
        wstrb_o = 4'b1111;
      end
    endcase
    if (!we_i) begin
      wstrb_o = 4'b0000;
    end
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage access controller: captures an EX-stage load/store, runs the SRAM
// address/data handshake while stalling the pipeline, and returns aligned data.
module mem_access_ctrl
  import mem_access_ctrl_pkg::*;
#(
  parameter int unsigned MAX_WAIT = MAX_WAIT_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        stallreq,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        sram_req,
  output logic        sram_wr,
  output logic [1:0]  sram_size,
  output logic [3:0]  sram_wstrb,
  output logic [31:0] sram_addr,
  output logic [31:0] sram_wdata,
  input  logic        sram_addr_ok,
  input  logic        sram_data_ok,
  input  logic [31:0] sram_rdata
);

  localparam int unsigned CNT_W = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);

  state_e            state_q, state_d;
  logic [31:0]       addr_q, addr_d;
  logic [1:0]        size_q, size_d;
  logic              we_q, we_d;
  logic              sgn_q, sgn_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              err_q, err_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc;
  logic              wd_hit, done_ok;
  logic              stall, sreq, rvalid, rerr;
  logic [3:0]        al_wstrb;
  logic [31:0]       al_wdata, al_rdata;

  assign cnt_inc = cnt_q + CNT_W'(1);
  assign wd_hit  = (MAX_WAIT != 0) && (cnt_inc == CNT_W'(MAX_WAIT));

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    size_d  = size_q;
    we_d    = we_q;
    sgn_d   = sgn_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    done_ok = 1'b0;
    stall   = 1'b0;
    sreq    = 1'b0;
    rvalid  = 1'b0;
    rerr    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          if (is_misaligned(req_size, req_addr[1:0])) begin
            rerr = 1'b1;
          end else begin
            addr_d  = req_addr;
            size_d  = req_size;
            we_d    = req_we;
            sgn_d   = req_signed;
            wdata_d = req_wdata;
            err_d   = 1'b0;
            cnt_d   = '0;
            stall   = 1'b1;
            state_d = ST_REQ;
          end
        end
      end
      ST_REQ, ST_WAIT: begin
        stall   = 1'b1;
        sreq    = (state_q == ST_REQ);
        cnt_d   = cnt_inc;
        // data_ok only counts once the address phase has been accepted
        done_ok = sram_data_ok && ((state_q == ST_WAIT) || sram_addr_ok);
        if (done_ok) begin
          rdata_d = sram_rdata;
          state_d = ST_DONE;
        end else if (wd_hit) begin
          err_d   = 1'b1;
          state_d = ST_DONE;
        end else if ((state_q == ST_REQ) && sram_addr_ok) begin
          state_d = ST_WAIT;
        end
      end
      ST_DONE: begin
        rvalid  = 1'b1;
        rerr    = err_q;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      size_q  <= '0;
      we_q    <= 1'b0;
      sgn_q   <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      size_q  <= size_d;
      we_q    <= we_d;
      sgn_q   <= sgn_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  mem_align u_align (
    .we_i     (we_q),
    .size_i   (size_q),
    .lsb_i    (addr_q[1:0]),
    .signed_i (sgn_q),
    .wdata_i  (wdata_q),
    .rdata_i  (rdata_q),
    .wstrb_o  (al_wstrb),
    .wdata_o  (al_wdata),
    .rdata_o  (al_rdata)
  );

  // IDLE outputs follow req_valid combinationally, so gate them with reset too.
  assign stallreq   = rst & stall;
  assign resp_err   = rst & rerr;
  assign resp_valid = rst & rvalid;
  assign resp_rdata = (rst && rvalid && !err_q && !we_q) ? al_rdata : 32'h0;
  assign sram_req   = rst & sreq;
  assign sram_wr    = we_q;
  assign sram_size  = size_q;
  assign sram_addr  = addr_q;
  assign sram_wstrb = al_wstrb;
  assign sram_wdata = al_wdata;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Scoreboard bench for mem_access_ctrl: directed cases plus randomized ops with
// random SRAM handshake latencies, checked against a lane-level reference model.
module tb_mem_access_ctrl;

  localparam int MW = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_we, req_signed;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        stallreq, resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic        sram_req, sram_wr;
  logic [1:0]  sram_size;
  logic [3:0]  sram_wstrb;
  logic [31:0] sram_addr, sram_wdata;
  logic        sram_addr_ok, sram_data_ok;
  logic [31:0] sram_rdata;

  mem_access_ctrl #(.MAX_WAIT(MW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_we(req_we), .req_size(req_size),
    .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
    .stallreq(stallreq), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .sram_req(sram_req), .sram_wr(sram_wr),
    .sram_size(sram_size), .sram_wstrb(sram_wstrb), .sram_addr(sram_addr),
    .sram_wdata(sram_wdata), .sram_addr_ok(sram_addr_ok),
    .sram_data_ok(sram_data_ok), .sram_rdata(sram_rdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic        v;
    logic        e;
    logic [31:0] d;
    int          at;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_chk = 0;
  int   n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int nbytes(input logic [1:0] sz);
    return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
  endfunction

  // Load result: pick the addressed bytes, then extend as an integer value.
  function automatic logic [31:0] model_load(input logic [1:0] sz, input logic sgn,
                                             input logic [31:0] addr, input logic [31:0] rd);
    longint v;
    int     nb;
    if (sz == 2'd2) return rd;
    nb = nbytes(sz);
    v  = longint'(rd >> (8 * addr[1:0])) % (longint'(1) << (8 * nb));
    if (sgn && v >= (longint'(1) << (8 * nb - 1))) v = v - (longint'(1) << (8 * nb));
    return v[31:0];
  endfunction

  function automatic logic [3:0] model_strb(input logic [1:0] sz, input logic [31:0] addr);
    logic [3:0] s;
    for (int i = 0; i < 4; i++)
      s[i] = (i >= int'(addr[1:0])) && (i < int'(addr[1:0]) + nbytes(sz));
    return s;
  endfunction

  function automatic logic [31:0] model_wdata(input logic [1:0] sz, input logic [31:0] wd);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = wd[8*(i % nbytes(sz)) +: 8];
    return r;
  endfunction

  // Monitor: every response pulse must match the oldest expected entry.
  always @(negedge clk) begin
    if (rst === 1'b1 && (resp_valid === 1'b1 || resp_err === 1'b1)) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_err++;
        $display("FAIL unexpected_resp: got valid=%0b err=%0b expected none (cycle %0d)",
                 resp_valid, resp_err, cyc);
      end else begin
        mon_e = exp_q.pop_front();
        chk("resp_valid", {31'h0, resp_valid}, {31'h0, mon_e.v});
        chk("resp_err", {31'h0, resp_err}, {31'h0, mon_e.e});
        chk("resp_rdata", resp_rdata, mon_e.d);
        chk("resp_cycle", cyc, mon_e.at);
      end
    end
  end

  // One access: addr_ok pulses a_lat cycles into REQ, data_ok d_lat cycles later.
  task automatic do_op(input logic we, input logic [1:0] sz, input logic sgn,
                       input logic [31:0] addr, input logic [31:0] wd,
                       input logic [31:0] rd, input int a_lat, input int d_lat);
    int   c0, k, resp_c, last_c;
    logic mis, to;
    mis = (sz == 2'd3) || ((addr % nbytes(sz)) != 0);
    @(posedge clk); #1;
    c0 = cyc;
    req_valid = 1'b1; req_we = we; req_size = sz; req_signed = sgn;
    req_addr = addr; req_wdata = wd;
    sram_addr_ok = 1'b0; sram_data_ok = 1'b0; sram_rdata = rd;
    if (mis) begin
      exp_q.push_back('{v: 1'b0, e: 1'b1, d: 32'h0, at: c0});
      @(negedge clk);
      chk("mis_stallreq", {31'h0, stallreq}, 32'h0);
      chk("mis_sram_req", {31'h0, sram_req}, 32'h0);
      @(posedge clk); #1;
      req_valid = 1'b0;
      @(negedge clk);
      chk("mis_sram_req_after", {31'h0, sram_req}, 32'h0);
      return;
    end
    k      = a_lat + d_lat + 1;
    to     = (k > MW);
    resp_c = to ? MW + 1 : k + 1;
    last_c = (k > resp_c) ? k : resp_c;
    exp_q.push_back('{v: 1'b1, e: to,
                      d: (to || we) ? 32'h0 : model_load(sz, sgn, addr, rd),
                      at: c0 + resp_c});
    for (int c = 0; c <= last_c; c++) begin
      if (c > 0) begin
        @(posedge clk); #1;
        req_valid    = (c <= resp_c);
        sram_addr_ok = (c == 1 + a_lat);
        sram_data_ok = (c == k);
      end
      @(negedge clk);
      if (c == 0) begin
        chk("c0_stallreq", {31'h0, stallreq}, 32'h1);
        chk("c0_sram_req", {31'h0, sram_req}, 32'h0);
      end
      if (c == 1) begin
        chk("req_sram_req", {31'h0, sram_req}, 32'h1);
        chk("req_stallreq", {31'h0, stallreq}, 32'h1);
        chk("req_sram_addr", sram_addr, addr);
        chk("req_sram_wr", {31'h0, sram_wr}, {31'h0, we});
        chk("req_sram_size", {30'h0, sram_size}, {30'h0, sz});
        chk("req_sram_wstrb", {28'h0, sram_wstrb}, we ? {28'h0, model_strb(sz, addr)} : 32'h0);
        if (we) chk("req_sram_wdata", sram_wdata, model_wdata(sz, wd));
      end
      if (c > 1 + a_lat && c < resp_c) begin
        chk("wait_sram_req", {31'h0, sram_req}, 32'h0);
        chk("wait_stallreq", {31'h0, stallreq}, 32'h1);
      end
      if (c == resp_c) chk("done_stallreq", {31'h0, stallreq}, 32'h0);
    end
    @(posedge clk); #1;
    req_valid = 1'b0; sram_addr_ok = 1'b0; sram_data_ok = 1'b0;
  endtask

  task automatic idle_gap(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      req_valid    = 1'b0;
      sram_addr_ok = 1'($urandom);
      sram_data_ok = 1'($urandom);
      sram_rdata   = $urandom;
    end
    @(posedge clk); #1;
    sram_addr_ok = 1'b0; sram_data_ok = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_signed = 1'b0;
    req_addr = 32'h0; req_wdata = 32'h0;
    sram_addr_ok = 1'b1; sram_data_ok = 1'b1; sram_rdata = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_stallreq", {31'h0, stallreq}, 32'h0);
    chk("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
    chk("rst_resp_err", {31'h0, resp_err}, 32'h0);
    chk("rst_sram_req", {31'h0, sram_req}, 32'h0);
    chk("rst_sram_addr", sram_addr, 32'h0);
    req_valid = 1'b0; sram_addr_ok = 1'b0; sram_data_ok = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;

    do_op(1'b0, 2'd2, 1'b0, 32'h100, 32'h0, 32'hDEADBEEF, 0, 0);
    do_op(1'b0, 2'd0, 1'b1, 32'h103, 32'h0, 32'h80112233, 0, 0);
    do_op(1'b0, 2'd0, 1'b0, 32'h103, 32'h0, 32'h80112233, 0, 0);
    do_op(1'b1, 2'd1, 1'b0, 32'h102, 32'h0000ABCD, 32'h5555AAAA, 0, 1);
    do_op(1'b0, 2'd2, 1'b0, 32'h101, 32'h0, 32'h12345678, 0, 0);
    do_op(1'b0, 2'd2, 1'b0, 32'h300, 32'h0, 32'h12345678, 8, 0);
    do_op(1'b0, 2'd1, 1'b1, 32'h206, 32'h0, 32'h8001_7FFF, 1, 2);

    // Reset in the middle of WAIT, then a stale data_ok.
    @(posedge clk); #1;
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_addr = 32'h200;
    @(posedge clk); #1;
    sram_addr_ok = 1'b1;
    @(posedge clk); #1;
    sram_addr_ok = 1'b0;
    chk("wait_before_rst_stallreq", {31'h0, stallreq}, 32'h1);
    #2;
    rst = 1'b0;
    #1;
    chk("midrst_stallreq", {31'h0, stallreq}, 32'h0);
    chk("midrst_sram_req", {31'h0, sram_req}, 32'h0);
    chk("midrst_sram_addr", sram_addr, 32'h0);
    chk("midrst_resp_valid", {31'h0, resp_valid}, 32'h0);
    chk("midrst_resp_err", {31'h0, resp_err}, 32'h0);
    req_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    sram_data_ok = 1'b1; sram_rdata = 32'hCAFEF00D;
    @(posedge clk); #1;
    sram_data_ok = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("post_rst_resp_valid", {31'h0, resp_valid}, 32'h0);
    end

    for (int n = 0; n < 150; n++) begin
      do_op(1'($urandom), 2'($urandom_range(0, 3)), 1'($urandom), $urandom, $urandom,
            $urandom, $urandom_range(0, 4), $urandom_range(0, 3));
      idle_gap($urandom_range(0, 2));
    end

    repeat (5) @(posedge clk);
    chk("pending_responses", exp_q.size(), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 Parameter MAX_WAIT, default 255, SHALL set the watchdog limit in cycles spent in REQ+WAIT; 0 disables the watchdog.
REQ-002 clk  input  1  sole clock; all state updates on posedge.
REQ-003 rst  input  1  asynchronous, active-low reset.
REQ-004 req_valid  input  1  EX-stage memory op present; held stable while stallreq=1.
REQ-005 req_we  input  1  1=store, 0=load.
REQ-006 req_size  input  2  00 byte, 01 half, 10 word, 11 reserved.
REQ-007 req_signed  input  1  load sign-extend enable.
REQ-008 req_addr  input  32  byte address.
REQ-009 req_wdata  input  32  store data, LSB-aligned.
REQ-010 stallreq  output  1  request to freeze the pipeline at and before MEM.
REQ-011 resp_valid  output  1  one-cycle completion pulse.
REQ-012 resp_rdata  output  32  aligned and extended load data; 0 for stores.
REQ-013 resp_err  output  1  one-cycle pulse on misalignment or watchdog expiry.
REQ-014 sram_req, sram_wr  output  1 each  SRAM request and write flag.
REQ-015 sram_size  output  2; sram_wstrb  output  4; sram_addr  output  32; sram_wdata  output  32.
REQ-016 sram_addr_ok, sram_data_ok  input  1 each; sram_rdata  input  32.

Function
REQ-017 FSM states SHALL be IDLE, REQ, WAIT, DONE.
REQ-018 IDLE: req_valid with an aligned address SHALL capture addr/size/we/signed/wdata, assert stallreq combinationally in the same cycle, and move to REQ.
REQ-019 Misalignment (half with addr[0]=1, word with addr[1:0]!=0, or size=11) SHALL pulse resp_err in that cycle, issue no SRAM access, keep stallreq=0, and remain in IDLE.
REQ-020 REQ: sram_req=1 with captured fields; addr_ok=1 SHALL move to WAIT, or to DONE if data_ok=1 in the same cycle.
REQ-021 WAIT: sram_req=0; data_ok=1 SHALL register sram_rdata and move to DONE.
REQ-022 DONE: resp_valid=1 and stallreq=0 for exactly one cycle, then IDLE; req_valid seen in DONE is the completing op and SHALL be ignored.
REQ-023 stallreq SHALL be 1 throughout REQ and WAIT.
REQ-024 Minimum latency: req_valid in cycle 0, addr_ok=data_ok=1 in cycle 1 gives resp_valid in cycle 2.
REQ-025 Store strobes: byte = 4'b0001<<addr[1:0]; half = 0011 (addr[1]=0) or 1100; word = 1111. Loads drive wstrb=0000.
REQ-026 Store data: byte replicated {4{wdata[7:0]}}, half {2{wdata[15:0]}}, word unchanged.
REQ-027 Load data SHALL be shifted right by addr[1:0]*8, then zero- or sign-extended from 8/16 bits per req_signed; word loads pass through unchanged.
REQ-028 sram_addr SHALL be the captured address with bits [1:0] unchanged.
REQ-029 Watchdog counter SHALL clear on entry to REQ and increment each REQ/WAIT cycle; reaching MAX_WAIT SHALL force DONE with resp_err=1, resp_valid=1, and resp_rdata=0.
REQ-030 data_ok or addr_ok arriving in IDLE or DONE SHALL be ignored.

Reset
REQ-031 rst=0 SHALL asynchronously force IDLE and clear the captured fields and the counter.
REQ-032 rst=0 SHALL drive every output to 0, including in the middle of an access.
REQ-033 A late data_ok for an access interrupted by reset SHALL be discarded.

Structure
REQ-034 Size encodings, FSM state encodings and the MAX_WAIT default SHALL live in the shared defines header.
REQ-035 The strobe, replication and load-extraction logic SHALL be a combinational sub-module mem_align.

Verification
REQ-036 Word load at 0x100 with addr_ok and data_ok both in cycle 1, rdata=0xDEADBEEF -> resp_valid in cycle 2, resp_rdata=0xDEADBEEF, stallreq high in cycles 0-1.
REQ-037 Signed byte load at 0x103 with rdata=0x80112233 -> resp_rdata=0xFFFFFF80; the same load unsigned -> 0x00000080.
REQ-038 Half store at 0x102 with wdata=0x0000ABCD -> wstrb=1100, sram_wdata=0xABCDABCD, wr=1.
REQ-039 Word load at 0x101 -> resp_err pulse, sram_req never high, stallreq=0.
REQ-040 MAX_WAIT=4 with addr_ok withheld -> resp_err and resp_valid in the cycle after the 4th wait cycle; a later data_ok is ignored.
REQ-041 rst low during WAIT -> outputs 0 at once; a subsequent data_ok causes no resp_valid.
